ramchip_ctrl: RTL and testbench

Synchronous initiator for the asynchronous `ramchip` SRAM model. It accepts single-word read/write requests over a valid/ready handshake and sequences the active-low chip-select, write-enable and output-enable strobes with programmable setup, access and hold phases. It captures read data and returns one response per request. It sits between the core's memory port and one `ramchip` instance, with the same `ADDRESS_SIZE`/`WORD_SIZE`.

---
 rtl/ramchip_pkg.sv | 18 +
 rtl/ramchip_phase_timer.sv | 26 ++
 rtl/ramchip_ctrl.sv | 153 +++++++++++++++
 tb/tb_ramchip_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramchip_pkg.sv
// Shared types and timing defaults for the ramchip SRAM initiator.
package ramchip_pkg;

    localparam int PHASE_CNT_W = 4;

    localparam int DEF_SETUP_CYCLES  = 1;
    localparam int DEF_ACCESS_CYCLES = 2;
    localparam int DEF_HOLD_CYCLES   = 1;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        ACCESS,
        HOLD,
        ERR
    } state_t;

endpackage

// File: rtl/ramchip_phase_timer.sv
// Loadable down-counter timing one strobe phase; done at zero.
module ramchip_phase_timer
    import ramchip_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic [PHASE_CNT_W-1:0] load_val,
    output logic                   done
);

    logic [PHASE_CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/ramchip_ctrl.sv
// Synchronous initiator sequencing CS/WE/OE strobes for an async SRAM.
module ramchip_ctrl
    import ramchip_pkg::*;
#(
    parameter int ADDRESS_SIZE  = 64,
    parameter int WORD_SIZE     = 32,
    parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
    parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
    parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDRESS_SIZE-1:0] req_addr,
    input  logic [WORD_SIZE-1:0]    req_wdata,
    output logic                    resp_valid,
    output logic [WORD_SIZE-1:0]    resp_rdata,
    output logic                    resp_err,
    output logic [ADDRESS_SIZE-1:0] ram_address,
    output logic [WORD_SIZE-1:0]    ram_wdata,
    input  logic [WORD_SIZE-1:0]    ram_rdata,
    output logic                    ram_cs_n,
    output logic                    ram_we_n,
    output logic                    ram_oe_n
);

    localparam logic [PHASE_CNT_W-1:0] SETUP_LD =
        PHASE_CNT_W'(SETUP_CYCLES - 1);
    localparam logic [PHASE_CNT_W-1:0] ACCESS_LD =
        PHASE_CNT_W'(ACCESS_CYCLES - 1);
    localparam logic [PHASE_CNT_W-1:0] HOLD_LD =
        PHASE_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [ADDRESS_SIZE-1:0] DEPTH =
        ADDRESS_SIZE'(ADDRESS_SIZE);

    state_t                 state;
    state_t                 state_nxt;
    logic                   we_q;
    logic [WORD_SIZE-1:0]   rdata_q;
    logic                   load;
    logic [PHASE_CNT_W-1:0] load_val;
    logic                   done;
    logic                   accept;
    logic                   in_range;
    logic                   hold_end;

    assign accept   = req_valid && req_ready;
    assign in_range = (req_addr < DEPTH);
    assign hold_end = (state == HOLD) && done;

    ramchip_phase_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        load_val  = SETUP_LD;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    if (in_range) begin
                        state_nxt = SETUP;
                        load      = 1'b1;
                        load_val  = SETUP_LD;
                    end else begin
                        state_nxt = ERR;
                    end
                end
            end
            SETUP: begin
                if (done) begin
                    state_nxt = ACCESS;
                    load      = 1'b1;
                    load_val  = ACCESS_LD;
                end
            end
            ACCESS: begin
                if (done) begin
                    state_nxt = HOLD;
                    load      = 1'b1;
                    load_val  = HOLD_LD;
                end
            end
            HOLD: begin
                if (done) begin
                    state_nxt = IDLE;
                end
            end
            ERR: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Strobes decode straight from state so reset raises them at once.
    always_comb begin
        req_ready = (state == IDLE);
        ram_cs_n  = !((state == SETUP) || (state == ACCESS)
                      || (state == HOLD));
        ram_we_n  = !((state == ACCESS) && we_q);
        ram_oe_n  = !((state == ACCESS) && !we_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_address <= '0;
            ram_wdata   <= '0;
            we_q        <= 1'b0;
            rdata_q     <= '0;
            resp_valid  <= 1'b0;
            resp_rdata  <= '0;
            resp_err    <= 1'b0;
        end else begin
            if (accept) begin
                we_q <= req_we;
            end
            if (accept && in_range) begin
                ram_address <= req_addr;
                ram_wdata   <= req_we ? req_wdata : '0;
            end
            if ((state == ACCESS) && done && !we_q) begin
                rdata_q <= ram_rdata;
            end
            resp_valid <= hold_end || (state == ERR);
            if (hold_end) begin
                resp_rdata <= we_q ? '0 : rdata_q;
                resp_err   <= 1'b0;
            end else if (state == ERR) begin
                resp_rdata <= '0;
                resp_err   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ramchip_ctrl.sv
// Directed bench: ramchip_ctrl against a small SRAM model, two timings.
module tb_ramchip_ctrl;
    import ramchip_pkg::*;

    localparam int AW = 64;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          valid0, valid1, req_we;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;

    logic          ready0, rv0, err0, cs0, we0, oe0;
    logic [DW-1:0] rdata0, wdata0, rram0;
    logic [AW-1:0] addr0;

    logic          ready1, rv1, err1, cs1, we1, oe1;
    logic [DW-1:0] rdata1, wdata1, rram1;
    logic [AW-1:0] addr1;

    logic [DW-1:0] mem [64];

    int checks = 0;
    int errors = 0;

    ramchip_ctrl #(.ADDRESS_SIZE(AW), .WORD_SIZE(DW)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid0), .req_ready(ready0),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(rv0), .resp_rdata(rdata0),
        .resp_err(err0),
        .ram_address(addr0), .ram_wdata(wdata0),
        .ram_rdata(rram0),
        .ram_cs_n(cs0), .ram_we_n(we0), .ram_oe_n(oe0)
    );

    ramchip_ctrl #(
        .ADDRESS_SIZE(AW), .WORD_SIZE(DW),
        .SETUP_CYCLES(3), .ACCESS_CYCLES(1),
        .HOLD_CYCLES(2)
    ) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(valid1), .req_ready(ready1),
        .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(rv1), .resp_rdata(rdata1),
        .resp_err(err1),
        .ram_address(addr1), .ram_wdata(wdata1),
        .ram_rdata(rram1),
        .ram_cs_n(cs1), .ram_we_n(we1), .ram_oe_n(oe1)
    );

    // Chip model: write while CS_n and WE_n are low, read drives on OE_n.
    always @(posedge clk) begin
        if (!cs0 && !we0 && addr0 < 64)
            mem[addr0[5:0]] <= wdata0;
    end

    assign rram0 = (!cs0 && !oe0 && addr0 < 64)
                   ? mem[addr0[5:0]] : '0;
    assign rram1 = '0;

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic run_req(
        input  bit            sel,
        input  bit            we,
        input  logic [63:0]   addr,
        input  logic [31:0]   wd,
        output int            period,
        output int            cs_lo,
        output int            we_lo,
        output int            oe_lo,
        output int            we_ofs,
        output int            addr_bad,
        output int            viol,
        output logic [31:0]   rd,
        output logic          er
    );
        int cs_first, we_first;
        logic c, w, o, v;
        logic [63:0] a;
        period = -1; cs_lo = 0; we_lo = 0; oe_lo = 0;
        addr_bad = 0; viol = 0; rd = '0; er = 1'b0;
        cs_first = -1; we_first = -1;
        @(negedge clk);
        req_we = we; req_addr = addr; req_wdata = wd;
        if (sel) valid1 = 1'b1;
        else valid0 = 1'b1;
        @(posedge clk);
        #1 valid0 = 1'b0; valid1 = 1'b0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            c = sel ? cs1 : cs0;
            w = sel ? we1 : we0;
            o = sel ? oe1 : oe0;
            v = sel ? rv1 : rv0;
            a = sel ? addr1 : addr0;
            if (!c) begin
                cs_lo++;
                if (cs_first < 0) cs_first = n;
                if (a != addr) addr_bad++;
            end
            if (!w) begin
                we_lo++;
                if (we_first < 0) we_first = n;
            end
            if (!o) oe_lo++;
            if ((!w && !o) || (c && (!w || !o))) viol++;
            if (v) begin
                period = n;
                rd = sel ? rdata1 : rdata0;
                er = sel ? err1 : err0;
                break;
            end
        end
        we_ofs = we_first - cs_first;
    endtask

    int per, csl, wel, oel, wof, abad, vio;
    logic [31:0] rd;
    logic er;
    int resp_n [2];
    int k, gap, acc2, stray;
    bit seen_lo, gap_done;
    logic [31:0] rd2;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = '0;
        valid0 = 0; valid1 = 0; req_we = 0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ready", ready0, 1);
        check("rst_cs", cs0, 1);
        check("rst_we", we0, 1);
        check("rst_oe", oe0, 1);
        check("rst_addr", addr0, 0);
        check("rst_wdata", wdata0, 0);
        check("rst_rv", rv0, 0);
        check("rst_rdata", rdata0, 0);
        check("rst_err", err0, 0);
        rst_n = 1'b1;

        run_req(0, 1, 5, 32'hDEADBEEF,
                per, csl, wel, oel, wof, abad, vio, rd, er);
        check("wr_period", per, 5);
        check("wr_cs_lo", csl, 4);
        check("wr_we_lo", wel, 2);
        check("wr_we_ofs", wof, 1);
        check("wr_oe_lo", oel, 0);
        check("wr_err", er, 0);
        check("wr_rdata", rd, 0);
        check("wr_viol", vio, 0);
        check("wr_addr", abad, 0);
        check("wr_idle_wd", wdata0, 32'hDEADBEEF);

        run_req(0, 0, 5, 32'h0,
                per, csl, wel, oel, wof, abad, vio, rd, er);
        check("rd_period", per, 5);
        check("rd_rdata", rd, 32'hDEADBEEF);
        check("rd_oe_lo", oel, 2);
        check("rd_we_lo", wel, 0);
        check("rd_err", er, 0);
        check("rd_viol", vio, 0);
        check("rd_wdata0", wdata0, 0);

        run_req(0, 0, 64, 32'h0,
                per, csl, wel, oel, wof, abad, vio, rd, er);
        check("oor_period", per, 2);
        check("oor_err", er, 1);
        check("oor_rdata", rd, 0);
        check("oor_cs_lo", csl, 0);

        // Back-to-back write then read with valid held high.
        resp_n[0] = -1; resp_n[1] = -1;
        k = 0; gap = 0; acc2 = 0;
        seen_lo = 0; gap_done = 0; rd2 = '0;
        @(negedge clk);
        req_we = 1; req_addr = 7;
        req_wdata = 32'h12345678; valid0 = 1;
        @(posedge clk);
        #1 req_we = 0;
        for (int n = 1; n <= 30 && k < 2; n++) begin
            @(negedge clk);
            if (!cs0) begin
                if (seen_lo && gap > 0) gap_done = 1;
                seen_lo = 1;
            end else if (seen_lo && !gap_done) begin
                gap++;
            end
            if (rv0) begin
                resp_n[k] = n;
                if (k == 0) acc2 = int'(ready0 && valid0);
                else rd2 = rdata0;
                k++;
                if (k == 1) begin
                    @(posedge clk);
                    #1 valid0 = 0;
                end
            end
        end
        valid0 = 0;
        check("b2b_resp1", resp_n[0], 5);
        check("b2b_acc2", acc2, 1);
        check("b2b_resp2", resp_n[1], 10);
        check("b2b_rdata", rd2, 32'h12345678);
        check("b2b_gap", gap, 1);

        run_req(1, 1, 3, 32'hA5A5A5A5,
                per, csl, wel, oel, wof, abad, vio, rd, er);
        check("slow_period", per, 7);
        check("slow_we_lo", wel, 1);
        check("slow_cs_lo", csl, 6);
        check("slow_addr", abad, 0);
        check("slow_we_ofs", wof, 3);
        check("slow_viol", vio, 0);

        // Reset during the ACCESS phase of a read.
        @(negedge clk);
        req_we = 0; req_addr = 5; valid0 = 1;
        @(posedge clk);
        #1 valid0 = 0;
        @(negedge clk);
        @(negedge clk);
        check("ar_pre_oe", oe0, 0);
        #2 rst_n = 1'b0;
        #1;
        check("ar_cs", cs0, 1);
        check("ar_oe", oe0, 1);
        check("ar_we", we0, 1);
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (8) begin
            @(negedge clk);
            if (rv0) stray++;
        end
        check("ar_no_resp", stray, 0);
        check("ar_ready", ready0, 1);
        run_req(0, 0, 5, 32'h0,
                per, csl, wel, oel, wof, abad, vio, rd, er);
        check("ar_rd_period", per, 5);
        check("ar_rd_rdata", rd, 32'hDEADBEEF);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
